microsequencer: RTL and testbench

Steps the CPU through microcode. It keeps the T-state counter and forms the microcode ROM address from the opcode and T-state. It injects the two fixed fetch microinstructions and drives the 16-bit `uinstr` word into the control decoder. It also stalls the datapath on a device-I/O handshake, with a timeout.

---
 rtl/scamp_pkg.sv | 41 ++++
 rtl/microsequencer_if.sv | 35 +++
 rtl/io_wait_timer.sv | 32 +++
 rtl/microsequencer.sv | 97 +++++++++
 tb/tb_microsequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scamp_pkg.sv
// rtl/scamp_pkg.sv - shared microcode constants, bus codes, uinstr field positions and sequencer state type
package scamp_pkg;

   localparam logic [15:0] FETCH0 = 16'h0020;
   localparam logic [15:0] FETCH1 = 16'h3440;

   localparam logic [2:0] BO_PC  = 3'd0;
   localparam logic [2:0] BO_IOH = 3'd1;
   localparam logic [2:0] BO_IOL = 3'd2;
   localparam logic [2:0] BO_MEM = 3'd3;
   localparam logic [2:0] BO_DEV = 3'd6;

   localparam logic [2:0] BI_MAR = 3'd1;
   localparam logic [2:0] BI_IR  = 3'd2;
   localparam logic [2:0] BI_MEM = 3'd3;
   localparam logic [2:0] BI_X   = 3'd4;
   localparam logic [2:0] BI_Y   = 3'd5;
   localparam logic [2:0] BI_DEV = 3'd6;

   localparam int UI_EO_N = 15;
   localparam int UI_BO_HI = 14;
   localparam int UI_BO_LO = 12;
   localparam int UI_RT    = 11;
   localparam int UI_BI_HI = 7;
   localparam int UI_BI_LO = 5;

   typedef enum logic {RUN, WAIT} seq_state_t;

   function automatic logic ui_is_do(input logic [15:0] u);
      return u[UI_EO_N] && (u[UI_BO_HI:UI_BO_LO] == BO_DEV);
   endfunction

   function automatic logic ui_is_di(input logic [15:0] u);
      return u[UI_BI_HI:UI_BI_LO] == BI_DEV;
   endfunction

   function automatic logic ui_is_rt(input logic [15:0] u);
      return u[UI_EO_N] && u[UI_RT];
   endfunction

endpackage

// File: rtl/microsequencer_if.sv
// rtl/microsequencer_if.sv - sequencer <-> ROM/decoder/device bundle
// SEQ_STEP_EN adds the step_mode/step single-step controls.
interface microsequencer_if #(parameter int TW = 3);
   logic [7:0]    ir_opcode;
   logic [15:0]   ucode_data;
   logic [7+TW:0] ucode_addr;
   logic [15:0]   uinstr;
   logic [TW-1:0] tstate;
   logic          dp_ce;
   logic          io_req;
   logic          io_ack;
   logic          io_timeout;
`ifdef SEQ_STEP_EN
   logic          step_mode;
   logic          step;

   modport master (
      input  ir_opcode, ucode_data, io_ack, step_mode, step,
      output ucode_addr, uinstr, tstate, dp_ce, io_req, io_timeout
   );
   modport slave (
      output ir_opcode, ucode_data, io_ack, step_mode, step,
      input  ucode_addr, uinstr, tstate, dp_ce, io_req, io_timeout
   );
`else
   modport master (
      input  ir_opcode, ucode_data, io_ack,
      output ucode_addr, uinstr, tstate, dp_ce, io_req, io_timeout
   );
   modport slave (
      output ir_opcode, ucode_data, io_ack,
      input  ucode_addr, uinstr, tstate, dp_ce, io_req, io_timeout
   );
`endif
endinterface

// File: rtl/io_wait_timer.sv
// rtl/io_wait_timer.sv - device-access wait counter with terminal count at IO_TIMEOUT-1
module io_wait_timer #(
   parameter int IO_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // The stalling RUN cycle already counts, so the first WAIT cycle sees 1.
   assign tc_o = (cnt_q >= 8'(IO_TIMEOUT - 1));

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - T-state sequencer with fetch injection and device-I/O stall/timeout
// Optional SEQ_STEP_EN: step_mode/step gate every advance of tstate, FSM and wait timer.
module microsequencer
   import scamp_pkg::*;
#(
   parameter int TSTATES    = 8,
   parameter int IO_TIMEOUT = 255
) (
   input logic             clk,
   input logic             reset,
   microsequencer_if.master sq
);

   localparam int TW = $clog2(TSTATES);

   logic [TW-1:0] tstate_q, tstate_d, tstate_adv;
   seq_state_t    state_q, state_d;
   logic          timeout_q, timeout_d;
   logic [15:0]   uinstr;
   logic          io_req, rt, stall, tc, timeout_now, go, cnt_clr, cnt_en;

`ifdef SEQ_STEP_EN
   assign go = !sq.step_mode || sq.step;
`else
   assign go = 1'b1;
`endif

   always_comb begin
      uinstr = sq.ucode_data;
      if (tstate_q == TW'(0))
         uinstr = FETCH0;
      else if (tstate_q == TW'(1))
         uinstr = FETCH1;
   end

   assign io_req      = ui_is_do(uinstr) || ui_is_di(uinstr);
   assign rt          = ui_is_rt(uinstr);
   assign stall       = io_req && !sq.io_ack;
   assign timeout_now = (state_q == WAIT) && tc && !sq.io_ack;
   assign tstate_adv  = rt ? '0 : tstate_q + TW'(1);

   always_comb begin
      state_d   = state_q;
      tstate_d  = tstate_q;
      timeout_d = timeout_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      if (go) begin
         if (state_q == RUN) begin
            if (stall) begin
               state_d = WAIT;
               cnt_en  = 1'b1;
            end else begin
               tstate_d = tstate_adv;
            end
         end else begin
            if (sq.io_ack || timeout_now) begin
               state_d   = RUN;
               tstate_d  = tstate_adv;
               cnt_clr   = 1'b1;
               timeout_d = timeout_q || timeout_now;
            end else begin
               cnt_en = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tstate_q  <= '0;
         state_q   <= RUN;
         timeout_q <= 1'b0;
      end else begin
         tstate_q  <= tstate_d;
         state_q   <= state_d;
         timeout_q <= timeout_d;
      end
   end

   io_wait_timer #(.IO_TIMEOUT(IO_TIMEOUT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (tc)
   );

   // The completing cycle (ack or timeout) keeps dp_ce high so the transfer commits once.
   assign sq.dp_ce      = go && !(stall && !timeout_now);
   assign sq.uinstr     = uinstr;
   assign sq.io_req     = io_req;
   assign sq.tstate     = tstate_q;
   assign sq.ucode_addr = {sq.ir_opcode, tstate_q};
   assign sq.io_timeout = timeout_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - directed bench with a cycle-counting reference model
module tb_microsequencer;

   localparam int NT = 8;
   localparam int TO = 255;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   int   m_t = 0;
   int   m_k = 0;
   bit   m_to = 1'b0;

   always #5 clk = ~clk;

   microsequencer_if #(.TW(3)) sq ();

   microsequencer #(.TSTATES(NT), .IO_TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .sq    (sq)
   );

   function automatic bit m_go();
`ifdef SEQ_STEP_EN
      return !sq.step_mode || sq.step;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [15:0] m_u();
      if (m_t == 0) return 16'h0020;
      if (m_t == 1) return 16'h3440;
      return sq.ucode_data;
   endfunction

   function automatic bit m_req();
      logic [15:0] u;
      u = m_u();
      return (u[15] && u[14:12] == 3'd6) || (u[7:5] == 3'd6);
   endfunction

   function automatic bit m_rt();
      logic [15:0] u;
      u = m_u();
      return u[15] && u[11];
   endfunction

   function automatic bit m_stall();
      return m_req() && !sq.io_ack;
   endfunction

   // Cycle m_k+1 of an unacknowledged access is the last one allowed when it equals TO.
   function automatic bit m_dpce();
      return m_go() && !(m_stall() && (m_k + 1 < TO));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_t  <= 0;
         m_k  <= 0;
         m_to <= 1'b0;
      end else if (m_go()) begin
         if (m_stall() && (m_k + 1 < TO)) begin
            m_k <= m_k + 1;
         end else begin
            if (m_stall()) m_to <= 1'b1;
            m_t <= m_rt() ? 0 : (m_t + 1) % NT;
            m_k <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("tstate", 32'(sq.tstate), 32'(m_t));
      chk("uinstr", 32'(sq.uinstr), 32'(m_u()));
      chk("io_req", 32'(sq.io_req), 32'(m_req()));
      chk("dp_ce", 32'(sq.dp_ce), 32'(m_dpce()));
      chk("io_timeout", 32'(sq.io_timeout), 32'(m_to));
      chk("ucode_addr", 32'(sq.ucode_addr), 32'({sq.ir_opcode, 3'(m_t)}));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(input int n);
      for (int i = 0; i < 40 && m_t != n; i++) cyc();
      if (m_t != n) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_step: tstate %0d want %0d", m_t, n);
      end
   endtask

   initial begin
      int n;
      logic [15:0] fetch_seq [3];
      fetch_seq[0] = 16'h0020;
      fetch_seq[1] = 16'h3440;
      fetch_seq[2] = 16'h0000;

      sq.ir_opcode  = 8'h00;
      sq.ucode_data = 16'h0000;
      sq.io_ack     = 1'b0;
`ifdef SEQ_STEP_EN
      sq.step_mode  = 1'b0;
      sq.step       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tstate", 32'(sq.tstate), 32'd0);
      chk("rst_uinstr", 32'(sq.uinstr), 32'h0020);
      chk("rst_dp_ce", 32'(sq.dp_ce), 32'd1);
      chk("rst_io_req", 32'(sq.io_req), 32'd0);
      chk("rst_timeout", 32'(sq.io_timeout), 32'd0);

      // Free run with ucode 0 and a stray ack that must be ignored.
      cyc();
      reset     = 1'b0;
      sq.io_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("run_tstate", 32'(sq.tstate), 32'(i % 8));
         if (i < 3) chk("run_uinstr", 32'(sq.uinstr), 32'(fetch_seq[i]));
      end

      // RT at T2 with opcode 0x12.
      cyc();
      sq.io_ack    = 1'b0;
      sq.ir_opcode = 8'h12;
      wait_step(2);
      sq.ucode_data = 16'h8800;
      @(negedge clk);
      chk("rt_addr", 32'(sq.ucode_addr), 32'h092);
      cyc();
      sq.ucode_data = 16'h0000;
      @(negedge clk);
      chk("rt_tstate", 32'(sq.tstate), 32'd0);

      // DI at T3, ack after four stalled cycles.
      wait_step(3);
      sq.ucode_data = 16'h80C0;
      repeat (4) begin
         @(negedge clk);
         chk("di_dp_ce_lo", 32'(sq.dp_ce), 32'd0);
         chk("di_tstate_hold", 32'(sq.tstate), 32'd3);
         cyc();
      end
      sq.io_ack = 1'b1;
      @(negedge clk);
      chk("di_dp_ce_ack", 32'(sq.dp_ce), 32'd1);
      chk("di_tstate_ack", 32'(sq.tstate), 32'd3);
      cyc();
      sq.io_ack     = 1'b0;
      sq.ucode_data = 16'h0000;
      @(negedge clk);
      chk("di_tstate_next", 32'(sq.tstate), 32'd4);

      // Single-cycle access at T6.
      wait_step(6);
      sq.ucode_data = 16'h80C0;
      sq.io_ack     = 1'b1;
      @(negedge clk);
      chk("fast_dp_ce", 32'(sq.dp_ce), 32'd1);
      cyc();
      sq.io_ack     = 1'b0;
      sq.ucode_data = 16'h0000;
      @(negedge clk);
      chk("fast_tstate", 32'(sq.tstate), 32'd7);

      // DI at T3 never acknowledged: timeout.
      wait_step(3);
      sq.ucode_data = 16'h80C0;
      n = 1;
      for (int g = 0; g < 300; g++) begin
         cyc();
         if (sq.tstate != 3'd3) break;
         n++;
      end
      sq.ucode_data = 16'h0000;
      chk("to_cycles", 32'(n), 32'd255);
      @(negedge clk);
      chk("to_flag", 32'(sq.io_timeout), 32'd1);
      wait_step(0);
      wait_step(2);
      @(negedge clk);
      chk("to_sticky", 32'(sq.io_timeout), 32'd1);

      // DO with RT at T5, ack after two stalled cycles.
      wait_step(5);
      sq.ucode_data = 16'hE800;
      repeat (2) begin
         @(negedge clk);
         chk("dort_hold", 32'(sq.tstate), 32'd5);
         chk("dort_dp_ce_lo", 32'(sq.dp_ce), 32'd0);
         cyc();
      end
      sq.io_ack = 1'b1;
      @(negedge clk);
      chk("dort_dp_ce_ack", 32'(sq.dp_ce), 32'd1);
      cyc();
      sq.io_ack     = 1'b0;
      sq.ucode_data = 16'h0000;
      @(negedge clk);
      chk("dort_tstate", 32'(sq.tstate), 32'd0);

      // Reset in the middle of a WAIT, with an ack present during reset.
      wait_step(3);
      sq.ucode_data = 16'h80C0;
      repeat (3) cyc();
      reset         = 1'b1;
      sq.ucode_data = 16'h0000;
      sq.io_ack     = 1'b1;
      cyc();
      reset     = 1'b0;
      sq.io_ack = 1'b0;
      @(negedge clk);
      chk("mrst_tstate", 32'(sq.tstate), 32'd0);
      chk("mrst_uinstr", 32'(sq.uinstr), 32'h0020);
      chk("mrst_timeout", 32'(sq.io_timeout), 32'd0);
      repeat (4) cyc();

`ifdef SEQ_STEP_EN
      begin
         logic [7:0] pat;
         pat   = 8'b0101_0010;
         reset = 1'b1;
         cyc();
         reset        = 1'b0;
         sq.step_mode = 1'b1;
         for (int i = 0; i < 8; i++) begin
            sq.step = pat[i];
            @(negedge clk);
            chk("step_dp_ce", 32'(sq.dp_ce), 32'(pat[i]));
            cyc();
         end
         sq.step = 1'b0;
         @(negedge clk);
         chk("step_tstate", 32'(sq.tstate), 32'd3);
         cyc();
         sq.step_mode = 1'b0;
         repeat (3) cyc();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
